sort_net_pipe: RTL and testbench
================================

Name: sort_net_pipe

Overview:
- Parametrised, fully pipelined bitonic sorting network. Accepts one N-element vector per beat and emits it sorted, ascending or descending per beat.
- Successor to the fixed 4-input, two-lanes-per-cycle sorter. Adds generic WIDTH/N, signed compare, a per-beat direction bit, and valid/ready flow control with backpressure.
- Sits between the sample-capture front end and the rank/median consumers.

Parameters:
- WIDTH, 32, bits per element.
- LOG2N, 2, log2 of element count; legal values 1..3, so N = 2^LOG2N = 2, 4 or 8.
- SIGNED, 0, 1 = two's-complement compare; 0 = unsigned compare.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  N*WIDTH  element i at [i*WIDTH +: WIDTH].
- in_desc  in  1  1 = sort descending; sampled with the beat.
- out_valid  out  1  sorted beat present.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  N*WIDTH  sorted vector; element 0 = min (ascending) or max (descending).
- out_desc  out  1  in_desc of the beat now on out_data.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Network: standard bitonic, L = LOG2N*(LOG2N+1)/2 compare-exchange layers (1, 3 or 6).
  - Each layer is followed by a register bank.
  - An input register bank (stage 0) precedes layer 1.
  - Total stages S = L+1.
- Each stage carries data, desc and a valid bit.
  - The desc bit selects the final direction by inverting every compare-exchange's swap condition for that beat.
  - Beats of mixed direction may be in flight together.
- Compare: signed or unsigned per SIGNED. On an equal compare, no swap.
- Flow control is a global stall: en = !out_valid || out_ready.
  - in_ready = en (combinational; no dependency on in_valid).
  - When en = 1, all stages shift by one; stage 0 valid <= in_valid.
  - When en = 0, all stages hold.
  - Bubbles are not collapsed.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+S-1, i.e. S cycles. At N=4 that is 4 cycles.
- Throughput: 1 beat/cycle while out_ready = 1.
- Output hold: out_data and out_desc are held stable while out_valid && !out_ready.
- Reset (async, rst = 0), applied immediately, even mid-operation:
  - All valid bits = 0, so out_valid = 0 and busy = 0.
  - All data registers = 0; out_data = 0 and out_desc = 0.
  - In-flight beats are discarded.
  - in_ready = 1 whenever rst = 1 and out_valid = 0.
- Boundary cases:
  - in_valid with in_ready = 0: beat is not taken; the source must hold it.
  - Simultaneous output accept and input accept: both occur in the same cycle.
  - All-equal inputs pass through unchanged.
  - Extreme values (0, all-ones, signed min/max) order correctly under each SIGNED setting.
- Element ordering is not stable without the optional feature.

Optional Feature:
- Macro SORT_INDEX_EN.
- Defined:
  - Each element carries a LOG2N-bit tag equal to its input position i, moved with the element through every swap.
  - Extra output out_idx (N*LOG2N bits); tag of output element j at [j*LOG2N +: LOG2N].
  - Equal values are ordered by lower tag first in ascending mode and higher tag first in descending mode. The result is a deterministic, stable permutation.
- Undefined:
  - No tags, no out_idx port.
  - Equal values are never swapped.

Test Plan:
- WIDTH=8, LOG2N=2, SIGNED=0, out_ready=1: in_data elements {9,3,7,1}, desc=0 -> 4 cycles later out {1,3,7,9}, out_desc=0, single-cycle out_valid.
- Same vector with desc=1 on the next beat -> consecutive outputs {1,3,7,9} then {9,7,3,1}; direction tracks each beat.
- SIGNED=1: {0x80,0x7F,0x00,0xFF} ascending -> {0x80,0xFF,0x00,0x7F}. With SIGNED=0 -> {0x00,0x7F,0x80,0xFF}.
- Backpressure: stream 6 beats, drop out_ready for 3 cycles after the first out_valid -> in_ready = 0 during the stall, out_data held, no loss or duplication, order preserved.
- Reset mid-stream: assert rst = 0 with 3 beats in flight -> immediately out_valid = 0, busy = 0, out_data = 0; after release, a new beat {4,4,2,2} -> {2,2,4,4}.
- SORT_INDEX_EN: {5,2,5,2} ascending -> out {2,2,5,5}, out_idx {1,3,0,2}. Descending -> out {5,5,2,2}, out_idx {2,0,3,1}.

Source files
------------

// File: rtl/sort_net_pipe_if.sv
// Stream bundle for sort_net_pipe: input beat, sorted output beat and busy flag.
// With SORT_INDEX_EN defined the bundle also carries out_idx (source position per output element).
interface sort_net_pipe_if #(
  parameter int WIDTH = 32,
  parameter int LOG2N = 2
);
  localparam int N = 1 << LOG2N;

  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               in_desc;
  logic               out_valid;
  logic               out_ready;
  logic [N*WIDTH-1:0] out_data;
  logic               out_desc;
  logic               busy;
`ifdef SORT_INDEX_EN
  logic [N*LOG2N-1:0] out_idx;

  modport master (output in_valid, in_data, in_desc, out_ready,
                  input  in_ready, out_valid, out_data, out_desc, busy, out_idx);
  modport slave  (input  in_valid, in_data, in_desc, out_ready,
                  output in_ready, out_valid, out_data, out_desc, busy, out_idx);
`else
  modport master (output in_valid, in_data, in_desc, out_ready,
                  input  in_ready, out_valid, out_data, out_desc, busy);
  modport slave  (input  in_valid, in_data, in_desc, out_ready,
                  output in_ready, out_valid, out_data, out_desc, busy);
`endif
endinterface

// File: rtl/sort_net_pipe.sv
// Fully pipelined bitonic sorter, N = 2^LOG2N elements per beat, per-beat direction, global stall.
// Optional SORT_INDEX_EN: elements carry their input position, ties broken by it, exposed as out_idx.
module sort_net_pipe #(
  parameter int WIDTH  = 32,
  parameter int LOG2N  = 2,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  sort_net_pipe_if.slave bus
);
  localparam int N  = 1 << LOG2N;
  localparam int L  = LOG2N * (LOG2N + 1) / 2;
  localparam int S  = L + 1;
  localparam int TW = LOG2N;

  logic [WIDTH-1:0] r_data [S][N];
  logic             r_desc [S];
  logic [S-1:0]     r_vld;
  logic [WIDTH-1:0] w_lay  [L][N];
  logic             w_en;
`ifdef SORT_INDEX_EN
  logic [TW-1:0]    r_tag  [S][N];
  logic [TW-1:0]    w_tag  [L][N];
`endif

  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    return (SIGNED != 0) ? (sa > sb) : (a > b);
  endfunction

  // A full output stage that is not being drained freezes the whole pipe.
  assign w_en         = !r_vld[S-1] || bus.out_ready;
  assign bus.in_ready = w_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      for (int s = 0; s < S; s++) begin
        r_desc[s] <= 1'b0;
        for (int i = 0; i < N; i++) begin
          r_data[s][i] <= '0;
`ifdef SORT_INDEX_EN
          r_tag[s][i]  <= '0;
`endif
        end
      end
    end else if (w_en) begin
      r_vld     <= {r_vld[S-2:0], bus.in_valid};
      r_desc[0] <= bus.in_desc;
      for (int i = 0; i < N; i++) begin
        r_data[0][i] <= bus.in_data[i*WIDTH +: WIDTH];
`ifdef SORT_INDEX_EN
        r_tag[0][i]  <= TW'(i);
`endif
      end
      // stage s+1 latches the output of compare-exchange layer s
      for (int s = 1; s < S; s++) begin
        r_desc[s] <= r_desc[s-1];
        for (int i = 0; i < N; i++) begin
          r_data[s][i] <= w_lay[s-1][i];
`ifdef SORT_INDEX_EN
          r_tag[s][i]  <= w_tag[s-1][i];
`endif
        end
      end
    end
  end

  // Merge phase k, sub-step at distance 2^J; local direction from bit k of the element index.
  for (genvar k = 1; k <= LOG2N; k++) begin : g_phase
    for (genvar jj = 0; jj < k; jj++) begin : g_layer
      localparam int J  = k - 1 - jj;
      localparam int LI = (k - 1) * k / 2 + jj;
      for (genvar i = 0; i < N; i++) begin : g_ce
        if (((i >> J) & 1) == 0) begin : g_pair
          localparam int P  = i + (1 << J);
          localparam bit UP = (((i >> k) & 1) == 0);
          logic w_agt;
          logic w_bgt;
          logic w_swap;
`ifdef SORT_INDEX_EN
          assign w_agt = gt(r_data[LI][i], r_data[LI][P]) ||
                         ((r_data[LI][i] == r_data[LI][P]) && (r_tag[LI][i] > r_tag[LI][P]));
          assign w_bgt = gt(r_data[LI][P], r_data[LI][i]) ||
                         ((r_data[LI][i] == r_data[LI][P]) && (r_tag[LI][P] > r_tag[LI][i]));
          assign w_tag[LI][i] = w_swap ? r_tag[LI][P] : r_tag[LI][i];
          assign w_tag[LI][P] = w_swap ? r_tag[LI][i] : r_tag[LI][P];
`else
          assign w_agt = gt(r_data[LI][i], r_data[LI][P]);
          assign w_bgt = gt(r_data[LI][P], r_data[LI][i]);
`endif
          // desc flips every comparator's direction; ties never swap
          assign w_swap = (UP ^ r_desc[LI]) ? w_agt : w_bgt;
          assign w_lay[LI][i] = w_swap ? r_data[LI][P] : r_data[LI][i];
          assign w_lay[LI][P] = w_swap ? r_data[LI][i] : r_data[LI][P];
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign bus.out_data[i*WIDTH +: WIDTH] = r_data[S-1][i];
`ifdef SORT_INDEX_EN
    assign bus.out_idx[i*TW +: TW]        = r_tag[S-1][i];
`endif
  end

  assign bus.out_valid = r_vld[S-1];
  assign bus.out_desc  = r_desc[S-1];
  assign bus.busy      = |r_vld;

endmodule

// File: tb/tb_sort_net_pipe.sv
// Bench for sort_net_pipe: an unsigned and a signed instance (WIDTH=8, N=4) share one stimulus stream.
module tb_sort_net_pipe;
  localparam int W  = 8;
  localparam int LG = 2;
  localparam int N  = 4;
  localparam int DW = N * W;

  typedef struct {
    logic [DW-1:0] d;
    logic          desc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_desc = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  sort_net_pipe_if #(.WIDTH(W), .LOG2N(LG)) if_u ();
  sort_net_pipe_if #(.WIDTH(W), .LOG2N(LG)) if_s ();

  assign if_u.in_valid  = in_valid;
  assign if_u.in_data   = in_data;
  assign if_u.in_desc   = in_desc;
  assign if_u.out_ready = out_ready;
  assign if_s.in_valid  = in_valid;
  assign if_s.in_data   = in_data;
  assign if_s.in_desc   = in_desc;
  assign if_s.out_ready = out_ready;

  sort_net_pipe #(.WIDTH(W), .LOG2N(LG), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(if_u));
  sort_net_pipe #(.WIDTH(W), .LOG2N(LG), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));

  // Reference: stable sort of (value, position) pairs, ascending or descending lexicographically.
  function automatic void ref_sort(input logic [DW-1:0] v, input logic desc, input bit sgn,
                                   output logic [DW-1:0] vals, output logic [N*LG-1:0] idx);
    int  key [N];
    int  pos [N];
    int  t;
    bit  ooo;
    for (int i = 0; i < N; i++) begin
      key[i] = sgn ? int'($signed(v[i*W +: W])) : int'(v[i*W +: W]);
      pos[i] = i;
    end
    for (int a = 0; a < N - 1; a++) begin
      for (int b = 0; b < N - 1 - a; b++) begin
        if (desc) ooo = (key[b] < key[b+1]) || ((key[b] == key[b+1]) && (pos[b] < pos[b+1]));
        else      ooo = (key[b] > key[b+1]) || ((key[b] == key[b+1]) && (pos[b] > pos[b+1]));
        if (ooo) begin
          t = key[b]; key[b] = key[b+1]; key[b+1] = t;
          t = pos[b]; pos[b] = pos[b+1]; pos[b+1] = t;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      vals[i*W +: W] = key[i][W-1:0];
      idx[i*LG +: LG] = pos[i][LG-1:0];
    end
  endfunction

  function automatic beat_t gen_beat();
    beat_t b;
    logic [W-1:0] e;
    b.desc = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0: e = 8'h00;
        1: e = 8'hFF;
        2: e = 8'h80;
        3: e = 8'h7F;
        4: e = (i == 0) ? 8'h80 : b.d[W-1:0];
        default: e = W'($urandom);
      endcase
      b.d[i*W +: W] = e;
    end
    if ($urandom_range(0, 7) == 0) b.d = {N{b.d[W-1:0]}};
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({if_u.out_valid, if_u.busy, if_u.out_desc, if_u.out_data,
         if_s.out_valid, if_s.busy, if_s.out_desc, if_s.out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got u=%b%b%b %h s=%b%b%b %h, expected all zero",
               if_u.out_valid, if_u.busy, if_u.out_desc, if_u.out_data,
               if_s.out_valid, if_s.busy, if_s.out_desc, if_s.out_data);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({if_u.in_ready, if_s.in_ready, if_u.out_valid, if_s.out_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL release_ready: got rdy=%b%b vld=%b%b, expected rdy=11 vld=00",
               if_u.in_ready, if_s.in_ready, if_u.out_valid, if_s.out_valid);
    end
  endtask

  task automatic test_direction();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h01_07_03_09; in_desc = 1'b0;
    tick();
    in_desc = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_chk++;
      if ({if_u.out_valid, if_s.out_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL early_valid: cycle %0d got %b%b, expected 00", c, if_u.out_valid, if_s.out_valid);
      end
      tick();
    end
    n_chk++;
    if ({if_u.out_valid, if_u.out_desc, if_u.out_data, if_s.out_valid, if_s.out_desc, if_s.out_data}
        !== {1'b1, 1'b0, 32'h09_07_03_01, 1'b1, 1'b0, 32'h09_07_03_01}) begin
      n_fail++;
      $display("FAIL asc_beat: got u=%b %b %h s=%b %b %h, expected 1 0 09070301",
               if_u.out_valid, if_u.out_desc, if_u.out_data, if_s.out_valid, if_s.out_desc, if_s.out_data);
    end
    tick();
    n_chk++;
    if ({if_u.out_valid, if_u.out_desc, if_u.out_data, if_s.out_valid, if_s.out_desc, if_s.out_data}
        !== {1'b1, 1'b1, 32'h01_03_07_09, 1'b1, 1'b1, 32'h01_03_07_09}) begin
      n_fail++;
      $display("FAIL desc_beat: got u=%b %b %h s=%b %b %h, expected 1 1 01030709",
               if_u.out_valid, if_u.out_desc, if_u.out_data, if_s.out_valid, if_s.out_desc, if_s.out_data);
    end
    tick();
    n_chk++;
    if ({if_u.out_valid, if_s.out_valid, if_u.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_valid: got vld=%b%b busy=%b, expected 000", if_u.out_valid, if_s.out_valid, if_u.busy);
    end
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hFF_00_7F_80; in_desc = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({if_u.out_valid, if_u.out_data} !== {1'b1, 32'hFF_80_7F_00}) begin
      n_fail++;
      $display("FAIL unsigned_extremes: got %b %h, expected 1 ff807f00", if_u.out_valid, if_u.out_data);
    end
    n_chk++;
    if ({if_s.out_valid, if_s.out_data} !== {1'b1, 32'h7F_00_FF_80}) begin
      n_fail++;
      $display("FAIL signed_extremes: got %b %h, expected 1 7f00ff80", if_s.out_valid, if_s.out_data);
    end
    tick();
  endtask

  // rnd=0: steady source, output stalled for 3 cycles from the first out_valid; rnd=1: random both sides.
  task automatic test_stream(input int nb, input bit rnd);
    beat_t           q[$];
    beat_t           cur;
    logic [DW-1:0]   eu, es;
    logic [N*LG-1:0] iu, isg;
    logic [2*DW+1:0] hv;
    logic            pstall;
    int              sent, got, cyc, first;
    sent = 0; got = 0; cyc = 0; first = -1; pstall = 1'b0; hv = '0;
    cur = gen_beat();
    while (got < nb && cyc < 2000) begin
      if (if_u.out_valid && first < 0) first = cyc;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else     out_ready = !(first >= 0 && cyc < first + 3);
      in_valid = (sent < nb) && (rnd ? ($urandom_range(0, 4) != 0) : 1'b1);
      in_data = cur.d; in_desc = cur.desc;
      #1;
      n_chk++;
      if ({if_u.in_ready, if_s.in_ready} !== {2{!if_u.out_valid || out_ready}}) begin
        n_fail++;
        $display("FAIL in_ready: cycle %0d got %b%b with out_valid=%b out_ready=%b",
                 cyc, if_u.in_ready, if_s.in_ready, if_u.out_valid, out_ready);
      end
      if (!rnd && first >= 0 && cyc < first + 3) begin
        n_chk++;
        if ({if_u.in_ready, if_s.in_ready} !== 2'b00) begin
          n_fail++;
          $display("FAIL stall_ready: cycle %0d got %b%b, expected 00", cyc, if_u.in_ready, if_s.in_ready);
        end
      end
      if (if_u.out_valid && pstall) begin
        n_chk++;
        if ({if_u.out_data, if_u.out_desc, if_s.out_data, if_s.out_desc} !== hv) begin
          n_fail++;
          $display("FAIL hold: cycle %0d got %h %b / %h %b, expected held %h", cyc,
                   if_u.out_data, if_u.out_desc, if_s.out_data, if_s.out_desc, hv);
        end
      end
      if (if_u.out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: cycle %0d got %h with nothing outstanding", cyc, if_u.out_data);
        end else begin
          ref_sort(q[0].d, q[0].desc, 1'b0, eu, iu);
          ref_sort(q[0].d, q[0].desc, 1'b1, es, isg);
          if ({if_s.out_valid, if_u.out_data, if_u.out_desc, if_s.out_data, if_s.out_desc}
              !== {1'b1, eu, q[0].desc, es, q[0].desc}) begin
            n_fail++;
            $display("FAIL stream_beat %0d: in %h desc %b got u=%h/%b s=%h/%b, expected u=%h s=%h",
                     got, q[0].d, q[0].desc, if_u.out_data, if_u.out_desc, if_s.out_data, if_s.out_desc, eu, es);
          end
`ifdef SORT_INDEX_EN
          n_chk++;
          if ({if_u.out_idx, if_s.out_idx} !== {iu, isg}) begin
            n_fail++;
            $display("FAIL stream_idx %0d: got %h %h, expected %h %h", got, if_u.out_idx, if_s.out_idx, iu, isg);
          end
`endif
          void'(q.pop_front());
          got++;
        end
      end
      pstall = if_u.out_valid && !out_ready;
      hv = {if_u.out_data, if_u.out_desc, if_s.out_data, if_s.out_desc};
      if (in_valid && if_u.in_ready) begin
        q.push_back(cur);
        sent++;
        cur = gen_beat();
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_chk++;
    if (got != nb || q.size() != 0 || {if_u.busy, if_s.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL drain: got %0d of %0d beats, %0d outstanding, busy=%b%b, expected all out and idle",
               got, nb, q.size(), if_u.busy, if_s.busy);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      in_data = $urandom; in_desc = b[0];
      tick();
    end
    in_valid = 1'b0;
    n_chk++;
    if ({if_u.out_valid, if_u.busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset: got vld=%b busy=%b, expected 11", if_u.out_valid, if_u.busy);
    end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({if_u.out_valid, if_u.busy, if_u.out_desc, if_u.out_data,
         if_s.out_valid, if_s.busy, if_s.out_desc, if_s.out_data} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got u=%b%b%b %h s=%b%b%b %h, expected all zero",
               if_u.out_valid, if_u.busy, if_u.out_desc, if_u.out_data,
               if_s.out_valid, if_s.busy, if_s.out_desc, if_s.out_data);
    end
    tick();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'h02_02_04_04; in_desc = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if ({if_u.out_valid, if_s.out_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL discarded: cycle %0d after reset got vld=%b%b, expected 00", c, if_u.out_valid, if_s.out_valid);
      end
      if (c < 2) tick();
    end
    tick();
    n_chk++;
    if ({if_u.out_valid, if_u.out_data, if_s.out_valid, if_s.out_data}
        !== {1'b1, 32'h04_04_02_02, 1'b1, 32'h04_04_02_02}) begin
      n_fail++;
      $display("FAIL post_reset_beat: got %b %h / %b %h, expected 1 04040202",
               if_u.out_valid, if_u.out_data, if_s.out_valid, if_s.out_data);
    end
    tick();
  endtask

`ifdef SORT_INDEX_EN
  task automatic test_index();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h02_05_02_05; in_desc = 1'b0;
    tick();
    in_desc = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({if_u.out_valid, if_u.out_data, if_u.out_idx} !== {1'b1, 32'h05_05_02_02, 8'h8D}) begin
      n_fail++;
      $display("FAIL idx_asc: got %b %h idx %h, expected 1 05050202 idx 8d", if_u.out_valid, if_u.out_data, if_u.out_idx);
    end
    tick();
    n_chk++;
    if ({if_u.out_valid, if_u.out_data, if_u.out_idx} !== {1'b1, 32'h02_02_05_05, 8'h72}) begin
      n_fail++;
      $display("FAIL idx_desc: got %b %h idx %h, expected 1 02020505 idx 72", if_u.out_valid, if_u.out_data, if_u.out_idx);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_direction();
    test_signed();
    test_stream(6, 1'b0);
    test_stream(60, 1'b1);
    test_reset_mid();
`ifdef SORT_INDEX_EN
    test_index();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
